// File: rtl/elim_pkg.sv
// Shared types and helpers for the flood-fill eliminator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package elim_pkg;

    // Controller states. COLLAPSE exists only when column collapsing is built in.
    typedef enum logic [2:0] {
        IDLE,
        SEED,
        GROW,
        CHECK,
        CLEAR,
        FALL,
        DONE
`ifdef COL_COLLAPSE_EN
        , COLLAPSE
`endif
    } state_t;

    // Colour code of an empty cell.
    localparam int EMPTY = 0;

    // Bit offset of cell (r,c) in a flattened row-major board.
    function automatic int idx(input int r, input int c, input int cols, input int cw);
        return (r * cols + c) * cw;
    endfunction

    // Width needed to hold a count in the range 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/elim_fall_step.sv
// One gravity step for a single column: the lowest hole with a filled cell above it is closed.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module elim_fall_step
    import elim_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int CW   = 3
) (
    input  logic [ROWS*CW-1:0] i_col,
    output logic [ROWS*CW-1:0] o_col,
    output logic               o_gap
);

    int   w_gap_row;
    logic w_seen;

    // Locate the deepest empty row below some filled cell, then shift everything above it down one.
    always_comb begin
        w_seen    = 1'b0;
        w_gap_row = 0;
        o_gap     = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (i_col[r*CW +: CW] == CW'(EMPTY)) begin
                if (w_seen) begin
                    o_gap     = 1'b1;
                    w_gap_row = r;
                end
            end else begin
                w_seen = 1'b1;
            end
        end
        o_col = i_col;
        if (o_gap) begin
            // Row 0 can never be the hole (nothing above it), so it always empties on a step.
            o_col[CW-1:0] = CW'(EMPTY);
            for (int r = 1; r < ROWS; r++) begin
                if (r <= w_gap_row) begin
                    o_col[r*CW +: CW] = i_col[(r-1)*CW +: CW];
                end
            end
        end
    end

endmodule

// File: rtl/flood_eliminate.sv
// Flood-fills the cursor's same-colour group, clears it if large enough, applies gravity, scores it.
// Latency: no-op 3 cycles start->done; otherwise 3 + grow cycles + fall cycles + 2.
// Backpressure: none; start is ignored while busy. COL_COLLAPSE_EN adds left-shift of emptied columns.
module flood_eliminate
    import elim_pkg::*;
#(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int CW        = 3,
    parameter int MIN_GROUP = 2,
    parameter int SCORE_W   = 7
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [$clog2(ROWS)-1:0]           cur_x,
    input  logic [$clog2(COLS)-1:0]           cur_y,
    input  logic [ROWS*COLS*CW-1:0]           board_in,
    input  logic                              new_game,
    output logic                              busy,
    output logic                              done,
    output logic                              eliminated,
    output logic [cnt_w(ROWS*COLS)-1:0]       removed_cnt,
    output logic [ROWS*COLS*CW-1:0]           board_out,
    output logic [SCORE_W-1:0]                score
);

    localparam int N    = ROWS * COLS;
    localparam int BW   = N * CW;
    localparam int CNTW = cnt_w(N);
    localparam int XW   = $clog2(ROWS);
    localparam int YW   = $clog2(COLS);
    localparam int SUMW = ((SCORE_W > CNTW) ? SCORE_W : CNTW) + 1;
    localparam logic [SCORE_W-1:0] SMAX = '1;

    state_t              r_state, w_state_nxt;
    logic [BW-1:0]       r_board, r_board_out;
    logic [XW-1:0]       r_cur_x;
    logic [YW-1:0]       r_cur_y;
    logic [CW-1:0]       r_seed;
    logic [N-1:0]        r_mask;
    logic [CNTW-1:0]     r_iter, r_removed;
    logic [SCORE_W-1:0]  r_score;
    logic                r_cleared, r_done, r_elim;

    logic                w_in_range;
    logic [CW-1:0]       w_cur_col;
    logic [N-1:0]        w_onehot, w_same, w_mask_nxt;
    logic [ROWS+1:0][COLS+1:0] w_pad;
    logic [CNTW-1:0]     w_cnt;
    logic [SUMW-1:0]     w_sum;
    logic [SCORE_W-1:0]  w_score_sat;
    logic [ROWS*CW-1:0]  w_col_in  [COLS];
    logic [ROWS*CW-1:0]  w_col_out [COLS];
    logic [COLS-1:0]     w_col_gap;
    logic [BW-1:0]       w_fall_board;

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign eliminated  = r_elim;
    assign removed_cnt = r_removed;
    assign board_out   = r_board_out;
    assign score       = r_score;

    // Decode the latched cursor: range check, one-hot seed mask and the colour under it.
    always_comb begin
        w_in_range = (int'(r_cur_x) < ROWS) && (int'(r_cur_y) < COLS);
        w_onehot   = '0;
        w_cur_col  = CW'(EMPTY);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (int'(r_cur_x) == r && int'(r_cur_y) == c) begin
                    w_onehot[r*COLS+c] = 1'b1;
                    w_cur_col          = r_board[idx(r, c, COLS, CW) +: CW];
                end
            end
        end
    end

    // One flood iteration; a zero border around the mask keeps neighbours from wrapping.
    always_comb begin
        w_pad      = '0;
        w_same     = '0;
        w_mask_nxt = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                w_pad[r+1][c+1] = r_mask[r*COLS+c];
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                w_same[r*COLS+c]     = (r_board[idx(r, c, COLS, CW) +: CW] == r_seed);
                w_mask_nxt[r*COLS+c] = r_mask[r*COLS+c] |
                                       (w_same[r*COLS+c] &
                                        (w_pad[r][c+1] | w_pad[r+2][c+1] |
                                         w_pad[r+1][c] | w_pad[r+1][c+2]));
            end
        end
    end

    // Group size and the saturated score it would produce.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N; i++) begin
            w_cnt = w_cnt + CNTW'(r_mask[i]);
        end
        w_sum       = SUMW'(r_score) + SUMW'(w_cnt);
        w_score_sat = (w_sum > SUMW'(SMAX)) ? SMAX : w_sum[SCORE_W-1:0];
    end

    // Split the working board into columns for the per-column gravity units.
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            w_col_in[c] = '0;
            for (int r = 0; r < ROWS; r++) begin
                w_col_in[c][r*CW +: CW] = r_board[idx(r, c, COLS, CW) +: CW];
            end
        end
    end

    for (genvar gc = 0; gc < COLS; gc++) begin : g_fall
        elim_fall_step #(
            .ROWS (ROWS),
            .CW   (CW)
        ) u_fall (
            .i_col (w_col_in[gc]),
            .o_col (w_col_out[gc]),
            .o_gap (w_col_gap[gc])
        );
    end

    // Reassemble the stepped columns into a flat board.
    always_comb begin
        w_fall_board = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                w_fall_board[idx(r, c, COLS, CW) +: CW] = w_col_out[c][r*CW +: CW];
            end
        end
    end

`ifdef COL_COLLAPSE_EN
    int            w_coll_k;
    logic          w_right_nz;
    logic          w_coll_any;
    logic [BW-1:0] w_coll_board;

    // Remove the leftmost empty column that still has a filled column to its right.
    always_comb begin
        w_right_nz = 1'b0;
        w_coll_any = 1'b0;
        w_coll_k   = COLS;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (w_col_in[c] == '0) begin
                if (w_right_nz) begin
                    w_coll_any = 1'b1;
                    w_coll_k   = c;
                end
            end else begin
                w_right_nz = 1'b1;
            end
        end
        w_coll_board = r_board;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS - 1; c++) begin
                if (c >= w_coll_k) begin
                    w_coll_board[idx(r, c, COLS, CW) +: CW] = r_board[idx(r, c + 1, COLS, CW) +: CW];
                end
            end
            if (w_coll_any) begin
                w_coll_board[idx(r, COLS - 1, COLS, CW) +: CW] = CW'(EMPTY);
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decisions.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (start) w_state_nxt = SEED;
            SEED:  w_state_nxt = (!w_in_range || w_cur_col == CW'(EMPTY)) ? DONE : GROW;
            GROW:  if (w_mask_nxt == r_mask || r_iter == CNTW'(N - 1)) w_state_nxt = CHECK;
            CHECK: w_state_nxt = (int'(w_cnt) < MIN_GROUP) ? DONE : CLEAR;
            CLEAR: w_state_nxt = FALL;
`ifdef COL_COLLAPSE_EN
            FALL:     if (w_col_gap == '0) w_state_nxt = COLLAPSE;
            COLLAPSE: if (!w_coll_any) w_state_nxt = DONE;
`else
            FALL:  if (w_col_gap == '0) w_state_nxt = DONE;
`endif
            DONE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: latch request, grow mask, clear and score, step gravity, publish result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_board     <= '0;
            r_board_out <= '0;
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_seed      <= '0;
            r_mask      <= '0;
            r_iter      <= '0;
            r_removed   <= '0;
            r_score     <= '0;
            r_cleared   <= 1'b0;
            r_done      <= 1'b0;
            r_elim      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (new_game) begin
                        r_score   <= '0;
                        r_removed <= '0;
                    end
                    if (start) begin
                        r_board   <= board_in;
                        r_cur_x   <= cur_x;
                        r_cur_y   <= cur_y;
                        r_cleared <= 1'b0;
                    end
                end
                SEED: begin
                    r_mask <= w_onehot;
                    r_seed <= w_cur_col;
                    r_iter <= '0;
                end
                GROW: begin
                    r_mask <= w_mask_nxt;
                    r_iter <= r_iter + 1'b1;
                end
                CLEAR: begin
                    for (int i = 0; i < N; i++) begin
                        if (r_mask[i]) r_board[i*CW +: CW] <= CW'(EMPTY);
                    end
                    r_removed <= w_cnt;
                    r_score   <= w_score_sat;
                    r_cleared <= 1'b1;
                end
                FALL: r_board <= w_fall_board;
`ifdef COL_COLLAPSE_EN
                COLLAPSE: r_board <= w_coll_board;
`endif
                DONE: begin
                    r_board_out <= r_board;
                    r_done      <= 1'b1;
                    r_elim      <= r_cleared;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flood_eliminate.sv
// Directed bench for flood_eliminate: 8x8 default build plus a 10x8 build for cursor range.
// Latency: n/a.
// Backpressure: n/a.
module tb_flood_eliminate;

    localparam int BW  = 192;
    localparam int BW2 = 240;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, new_game;
    logic [2:0]     cur_x, cur_y;
    logic [BW-1:0]  board_in, board_out;
    logic           busy, done, eliminated;
    logic [6:0]     removed_cnt, score;

    logic           start2, new_game2;
    logic [3:0]     cur_x2;
    logic [2:0]     cur_y2;
    logic [BW2-1:0] board_in2, board_out2;
    logic           busy2, done2, eliminated2;
    logic [6:0]     removed_cnt2, score2;

    int n_cmp  = 0;
    int n_fail = 0;

    flood_eliminate u_dut (
        .clk(clk), .rst(rst), .start(start), .cur_x(cur_x), .cur_y(cur_y),
        .board_in(board_in), .new_game(new_game), .busy(busy), .done(done),
        .eliminated(eliminated), .removed_cnt(removed_cnt), .board_out(board_out),
        .score(score)
    );

    flood_eliminate #(.ROWS(10)) u_dut10 (
        .clk(clk), .rst(rst), .start(start2), .cur_x(cur_x2), .cur_y(cur_y2),
        .board_in(board_in2), .new_game(new_game2), .busy(busy2), .done(done2),
        .eliminated(eliminated2), .removed_cnt(removed_cnt2), .board_out(board_out2),
        .score(score2)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checkerboard of colours 1/3: no two neighbours share a colour.
    function automatic logic [BW-1:0] chk8();
        logic [BW-1:0] b;
        b = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[(r*8+c)*3 +: 3] = ((r + c) % 2 == 1) ? 3'd1 : 3'd3;
        return b;
    endfunction

    function automatic logic [BW2-1:0] chk10();
        logic [BW2-1:0] b;
        b = '0;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 8; c++)
                b[(r*8+c)*3 +: 3] = ((r + c) % 2 == 1) ? 3'd1 : 3'd3;
        return b;
    endfunction

    function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int r, input int c, input logic [2:0] v);
        b[(r*8+c)*3 +: 3] = v;
        return b;
    endfunction

    function automatic logic [2:0] get(input logic [BW-1:0] b, input int r, input int c);
        return b[(r*8+c)*3 +: 3];
    endfunction

    // Issue one request to the 8x8 unit and wait (bounded) for done; n = edges from start to done.
    task automatic run(input logic [BW-1:0] b, input int x, input int y, input logic ng, output int n);
        board_in = b; cur_x = 3'(x); cur_y = 3'(y); new_game = ng; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; new_game = 1'b0; board_in = ~b;
        n = 1;
        chk("busy_after_start", busy, 1);
        while (done !== 1'b1 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("done_seen", done, 1);
        chk("busy_low_with_done", busy, 0);
    endtask

    task automatic run10(input logic [BW2-1:0] b, input int x, input int y, output int n);
        board_in2 = b; cur_x2 = 4'(x); cur_y2 = 3'(y); start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 1;
        while (done2 !== 1'b1 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("done10_seen", done2, 1);
    endtask

    logic [BW-1:0]  b, e;
    logic [BW2-1:0] b10;
    logic           saw_done;
    int             n;

    initial begin
        rst = 1'b1; start = 1'b0; new_game = 1'b0; cur_x = '0; cur_y = '0; board_in = '0;
        start2 = 1'b0; new_game2 = 1'b0; cur_x2 = '0; cur_y2 = '0; board_in2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_board_out", board_out, 0);
        chk("rst_score", score, 0);
        chk("rst_removed", removed_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_elim", eliminated, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Isolated colour-5 cell at (7,0): group of 1, nothing removed.
        b = put(chk8(), 7, 0, 3'd5);
        run(b, 7, 0, 1'b0, n);
        chk("iso_elim", eliminated, 0);
        chk("iso_board", board_out, b);
        chk("iso_score", score, 0);
        @(posedge clk); #1;
        chk("iso_done_one_cycle", done, 0);
        chk("iso_board_held", board_out, b);

        // L-shaped colour-2 group, cursor at (7,3).
        b = chk8();
        b = put(b, 7, 3, 3'd2); b = put(b, 7, 4, 3'd2);
        b = put(b, 6, 4, 3'd2); b = put(b, 5, 4, 3'd2);
        e = b;
        for (int r = 7; r >= 1; r--) e = put(e, r, 3, get(b, r - 1, 3));
        e = put(e, 0, 3, 3'd0);
        for (int r = 7; r >= 3; r--) e = put(e, r, 4, get(b, r - 3, 4));
        for (int r = 0; r < 3; r++) e = put(e, r, 4, 3'd0);
        run(b, 7, 3, 1'b0, n);
        chk("l_elim", eliminated, 1);
        chk("l_removed", removed_cnt, 4);
        chk("l_score", score, 4);
        chk("l_board", board_out, e);
        chk("l_cell_7_4", get(board_out, 7, 4), 3);
        chk("l_cell_7_3", get(board_out, 7, 3), 1);
        chk("l_cell_2_4", get(board_out, 2, 4), 0);

        // Cursor on an empty cell: no-op path, done three edges after start.
        b = put(chk8(), 3, 3, 3'd0);
        run(b, 3, 3, 1'b0, n);
        chk("empty_latency", n, 3);
        chk("empty_elim", eliminated, 0);
        chk("empty_board", board_out, b);
        chk("empty_score", score, 4);
        chk("empty_removed", removed_cnt, 4);

        // 10-row build: empty cell on the bottom row, then a row index past the board.
        b10 = chk10();
        b10[(9*8+5)*3 +: 3] = 3'd0;
        run10(b10, 9, 5, n);
        chk("r10_empty_latency", n, 3);
        chk("r10_empty_elim", eliminated2, 0);
        chk("r10_empty_board", board_out2, b10);
        b10 = chk10();
        run10(b10, 12, 2, n);
        chk("r10_oor_latency", n, 3);
        chk("r10_oor_elim", eliminated2, 0);
        chk("r10_oor_board", board_out2, b10);
        chk("r10_score", score2, 0);

        // Whole of column 2 in colour 5.
        b = chk8();
        for (int r = 0; r < 8; r++) b = put(b, r, 2, 3'd5);
        e = chk8();
`ifdef COL_COLLAPSE_EN
        for (int r = 0; r < 8; r++) begin
            for (int c = 2; c < 7; c++) e = put(e, r, c, get(chk8(), r, c + 1));
            e = put(e, r, 7, 3'd0);
        end
`else
        for (int r = 0; r < 8; r++) e = put(e, r, 2, 3'd0);
`endif
        run(b, 0, 2, 1'b0, n);
        chk("col_elim", eliminated, 1);
        chk("col_removed", removed_cnt, 8);
        chk("col_score", score, 12);
        chk("col_board", board_out, e);

        // new_game together with start on an all-colour-1 board.
        b = '0;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) b = put(b, r, c, 3'd1);
        run(b, 4, 4, 1'b1, n);
        chk("full_removed", removed_cnt, 64);
        chk("full_score", score, 64);
        chk("full_board", board_out, 0);

        // 62-cell group brings the score to 126.
        b = put(b, 0, 0, 3'd2); b = put(b, 0, 1, 3'd2);
        e = '0; e = put(e, 7, 0, 3'd2); e = put(e, 7, 1, 3'd2);
        run(b, 7, 7, 1'b0, n);
        chk("g62_removed", removed_cnt, 62);
        chk("g62_score", score, 126);
        chk("g62_board", board_out, e);

        // 3-cell group saturates the score.
        b = chk8();
        for (int c = 0; c < 3; c++) b = put(b, 7, c, 3'd4);
        e = chk8();
        for (int c = 0; c < 3; c++) begin
            for (int r = 7; r >= 1; r--) e = put(e, r, c, get(chk8(), r - 1, c));
            e = put(e, 0, c, 3'd0);
        end
        run(b, 7, 1, 1'b0, n);
        chk("sat_removed", removed_cnt, 3);
        chk("sat_score", score, 127);
        chk("sat_board", board_out, e);

        // Reset while falling: L-shape again, reset after eight edges (inside FALL).
        b = chk8();
        b = put(b, 7, 3, 3'd2); b = put(b, 7, 4, 3'd2);
        b = put(b, 6, 4, 3'd2); b = put(b, 5, 4, 3'd2);
        board_in = b; cur_x = 3'd7; cur_y = 3'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("fall_busy", busy, 1);
        chk("fall_board_prev", board_out, e);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_board", board_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_score", score, 0);
        chk("abort_elim", eliminated, 0);
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            saw_done = saw_done | (done === 1'b1);
        end
        chk("abort_no_done", saw_done, 0);

        // Normal operation after the abort.
        b = put(chk8(), 7, 0, 3'd5);
        run(b, 7, 0, 1'b0, n);
        chk("post_elim", eliminated, 0);
        chk("post_board", board_out, b);
        chk("post_removed", removed_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
